// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes,
// FSM states and a wide two's-complement negate helper.
package mdu_pkg;

  // Widest value the negate helper handles; covers 2*WIDTH for WIDTH <= 64.
  localparam int unsigned MDU_NEG_W = 128;

  // op[0] = signed, op[1] = divide
  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } mdu_state_e;

  // Two's-complement negate; callers zero-extend in and truncate out.
  function automatic logic [MDU_NEG_W-1:0] mdu_neg(input logic [MDU_NEG_W-1:0] x);
    return ~x + MDU_NEG_W'(1);
  endfunction

endpackage

// File: rtl/mdu_multicycle_if.sv
// Start/done request and result bus between the controller and the MDU.
interface mdu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opr_a;
  logic [WIDTH-1:0] opr_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  modport master (
    output start, op, opr_a, opr_b,
    input  busy, done, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, op, opr_a, opr_b,
    output busy, done, result_hi, result_lo, div_by_zero
  );
endinterface

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step on {rem, quot} with a
// WIDTH+1-bit trial subtract.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx_c,
  output logic [WIDTH-1:0] quot_nx_c
);
  localparam int unsigned SW = WIDTH + 1;

  logic [SW-1:0] shifted;
  logic [SW-1:0] diff;
  logic          ge;

  // Shift in the next dividend bit, keep the difference if it did not borrow.
  always_comb begin
    shifted   = {rem_in, quot_in[WIDTH-1]};
    diff      = shifted - SW'(divisor);
    ge        = (shifted >= SW'(divisor));
    rem_nx_c  = ge ? WIDTH'(diff) : WIDTH'(shifted);
    quot_nx_c = {quot_in[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/mdu_multicycle.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Optional build macro MDU_FAST_MULT_EN: multiplies finish in PREP with a
// single-cycle multiplier; divides are unaffected.
module mdu_multicycle
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mdu_multicycle_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  mdu_state_e       state, state_nx;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q;   // product high / partial remainder
  logic [WIDTH-1:0] mq_q;    // multiplier / quotient
  logic [WIDTH-1:0] dvs_q;   // multiplicand / divisor (magnitude)
  logic             neg_lo_q, neg_hi_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             accept_c;
  logic             sign_a_c, sign_b_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] rem_nx_c, quot_nx_c;
  logic [PW-1:0]    prod_neg_c;
  logic [WIDTH-1:0] fix_hi_c, fix_lo_c;
`ifdef MDU_FAST_MULT_EN
  logic [PW-1:0]    ext_a_c, ext_b_c, fast_prod_c;
`endif

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.result_hi   = hi_q;
  assign bus.result_lo   = lo_q;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in   (acc_q),
    .quot_in  (mq_q),
    .divisor  (dvs_q),
    .rem_nx_c (rem_nx_c),
    .quot_nx_c(quot_nx_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_nx = PREP;
        end
      end
      PREP: begin
`ifdef MDU_FAST_MULT_EN
        state_nx = op_q[1] ? CALC : DONE;
`else
        state_nx = CALC;
`endif
      end
      CALC: begin
        if (cnt_q == CNT_W'(1)) state_nx = FIX;
      end
      FIX:  state_nx = DONE;
      DONE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_nx = PREP;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand magnitudes, one shift-add step and the sign fix-up.
  always_comb begin
    sign_a_c   = op_q[0] & a_q[WIDTH-1];
    sign_b_c   = op_q[0] & b_q[WIDTH-1];
    abs_a_c    = sign_a_c ? WIDTH'(mdu_neg(MDU_NEG_W'(a_q))) : a_q;
    abs_b_c    = sign_b_c ? WIDTH'(mdu_neg(MDU_NEG_W'(b_q))) : b_q;
    sum_c      = (WIDTH+1)'(acc_q) + (mq_q[0] ? (WIDTH+1)'(dvs_q) : (WIDTH+1)'(0));
    prod_neg_c = PW'(mdu_neg(MDU_NEG_W'({acc_q, mq_q})));
    if (!op_q[1]) begin
      fix_hi_c = neg_hi_q ? prod_neg_c[PW-1:WIDTH] : acc_q;
      fix_lo_c = neg_hi_q ? prod_neg_c[WIDTH-1:0]  : mq_q;
    end else if (b_q == '0) begin
      fix_hi_c = a_q;
      fix_lo_c = '1;
    end else begin
      fix_hi_c = neg_hi_q ? WIDTH'(mdu_neg(MDU_NEG_W'(acc_q))) : acc_q;
      fix_lo_c = neg_lo_q ? WIDTH'(mdu_neg(MDU_NEG_W'(mq_q)))  : mq_q;
    end
  end

`ifdef MDU_FAST_MULT_EN
  // Single-cycle product; sign-extending to 2*WIDTH makes one multiplier serve both modes.
  always_comb begin
    ext_a_c     = op_q[0] ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : PW'(a_q);
    ext_b_c     = op_q[0] ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : PW'(b_q);
    fast_prod_c = ext_a_c * ext_b_c;
  end
`endif

  // Operand latch and iterative datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      dvs_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (accept_c) begin
        op_q <= bus.op;
        a_q  <= bus.opr_a;
        b_q  <= bus.opr_b;
      end
      case (state)
        PREP: begin
          acc_q    <= '0;
          mq_q     <= op_q[1] ? abs_a_c : abs_b_c;
          dvs_q    <= op_q[1] ? abs_b_c : abs_a_c;
          neg_lo_q <= sign_a_c ^ sign_b_c;
          neg_hi_q <= op_q[1] ? sign_a_c : (sign_a_c ^ sign_b_c);
          cnt_q    <= CNT_W'(WIDTH);
        end
        CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_q[1]) begin
            acc_q <= rem_nx_c;
            mq_q  <= quot_nx_c;
          end else begin
            acc_q <= sum_c[WIDTH:1];
            mq_q  <= {sum_c[0], mq_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= (state_nx == PREP) || (state_nx == CALC) || (state_nx == FIX);
      done_q <= (state_nx == DONE);
      dbz_q  <= (state == FIX) && op_q[1] && (b_q == '0);
      if (state == FIX) begin
        hi_q <= fix_hi_c;
        lo_q <= fix_lo_c;
      end
`ifdef MDU_FAST_MULT_EN
      if ((state == PREP) && !op_q[1]) begin
        hi_q <= fast_prod_c[PW-1:WIDTH];
        lo_q <= fast_prod_c[WIDTH-1:0];
      end
`endif
    end
  end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Scoreboard bench for mdu_multicycle (WIDTH=32); honours MDU_FAST_MULT_EN.
module tb_mdu_multicycle;
  localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 35;
`endif
  localparam int DIV_LAT = 35;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  mdu_multicycle_if #(.WIDTH(W)) bus ();

  mdu_multicycle #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sbv, q, r;
    logic [63:0] p;
    e.dbz = 1'b0;
    e.lat = op[1] ? DIV_LAT : MUL_LAT;
    if (!op[1]) begin
      if (op[0]) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else       p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else if (op[0]) begin
      sa   = longint'($signed(a));
      sbv  = longint'($signed(b));
      q    = sa / sbv;
      r    = sa % sbv;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Drive a request and log its expected outcome.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opr_a = a;
    bus.opr_b = b;
    sb_q.push_back(model(op, a, b));
  endtask

  // Called #1 after the edge that accepted start; waits for done and scores it.
  task automatic wait_result(input bit poke);
    exp_t e;
    int   cyc;
    int   lat;
    cyc = 1;
    lat = (sb_q.size() > 0) ? sb_q[0].lat : 0;
    check("busy_first", 64'(bus.busy), 64'(1));
    check("done_first", 64'(bus.done), 64'(0));
    while (!bus.done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke && (cyc == 5 || cyc == 20)) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.opr_a = 32'h3;
        bus.opr_b = 32'h5;
      end else begin
        bus.start = 1'b0;
      end
      if (cyc == lat - 1 && lat > 2) check("busy_last", 64'(bus.busy), 64'(1));
    end
    check("done", 64'(bus.done), 64'(1));
    check("busy_at_done", 64'(bus.busy), 64'(0));
    check("latency", 64'(cyc), 64'(lat));
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'(0), 64'(1));
    end else begin
      e = sb_q.pop_front();
      check("hi", 64'(bus.result_hi), 64'(e.hi));
      check("lo", 64'(bus.result_lo), 64'(e.lo));
      check("dbz", 64'(bus.div_by_zero), 64'(e.dbz));
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    issue(op, a, b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_result(1'b0);
  endtask

  initial begin
    logic [W-1:0] hold_hi, hold_lo;
    bit           seen;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opr_a = '0;
    bus.opr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_hi", 64'(bus.result_hi), 64'(0));
    check("rst_lo", 64'(bus.result_lo), 64'(0));
    check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
    reset = 1'b0;

    // Directed vectors.
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", 64'(bus.result_hi), 64'(32'hFFFF_FFFE));
    run(2'b01, 32'hFFFF_FFF9, 32'd3);
    check("mult_neg_lo", 64'(bus.result_lo), 64'(32'hFFFF_FFEB));
    run(2'b11, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo", 64'(bus.result_lo), 64'(32'hFFFF_FFFD));
    run(2'b10, 32'd100, 32'd0);
    run(2'b11, 32'd100, 32'd0);
    run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", 64'(bus.result_lo), 64'(32'h8000_0000));
    run(2'b00, 32'h1234_5678, 32'h10);
    check("fast_vec_hi", 64'(bus.result_hi), 64'(32'h1));
    run(2'b10, 32'd5, 32'd9);
    run(2'b01, 32'h8000_0000, 32'h8000_0000);

    // start while busy must be ignored; result then holds.
    @(negedge clk);
    issue(2'b10, 32'd1000, 32'd7);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_result(1'b1);
    hold_hi = bus.result_hi;
    hold_lo = bus.result_lo;
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", 64'(bus.done), 64'(0));
    check("hold_hi", 64'(bus.result_hi), 64'(32'd6));
    check("hold_lo", 64'(bus.result_lo), 64'(32'd142));

    // Back-to-back: start held in the DONE cycle.
    run(2'b11, 32'hFFFF_FF00, 32'd9);
    issue(2'b01, 32'd12345, 32'hFFFF_FF85);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_result(1'b0);

    // Reset at cycle 10 of a divide aborts with no done.
    @(negedge clk);
    issue(2'b11, 32'd77777, 32'd13);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(sb_q.pop_back());
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_hi", 64'(bus.result_hi), 64'(0));
    check("abort_lo", 64'(bus.result_lo), 64'(0));
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'(0));

    // Random mix.
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 4 == 1) ra = -ra;
      run(rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Parametrised multi-cycle multiply/divide unit for the multi-cycle MIPS core.
- Replaces the separate combinational multiplier and fixed 32-bit divider with one start/done block.
- Handles MULT, MULTU, DIV and DIVU, and writes HI/LO results through the controller.
- Iterative radix-2 datapath: one shift-add or restoring-subtract step per cycle, operand width set by a parameter.

Parameters:
- WIDTH, 32, operand width in bits; result_hi and result_lo are each WIDTH bits; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; accepted only in IDLE or DONE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (op[0] = signed, op[1] = divide).
- opr_a  input  WIDTH  multiplicand or dividend (rs); sampled only on the accepted start.
- opr_b  input  WIDTH  multiplier or divisor (rt); sampled only on the accepted start.
- busy  output  1  high in PREP, CALC and FIX.
- done  output  1  one-cycle pulse when results are valid.
- result_hi  output  WIDTH  product high half, or remainder.
- result_lo  output  WIDTH  product low half, or quotient.
- div_by_zero  output  1  pulses with done when a divide had opr_b == 0.

Behaviour:
- Reset (synchronous, active-high) returns state to IDLE and clears busy, done, div_by_zero, result_hi, result_lo and the counter to 0. Reset mid-operation aborts with no done.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE + start: latch op, opr_a and opr_b, then go to PREP.
- PREP: latch absolute values when op[0]=1; record result signs:
  - product sign = sign_a XOR sign_b;
  - quotient sign = sign_a XOR sign_b;
  - remainder sign = sign_a.
  - Load counter = WIDTH. Next state CALC.
- CALC, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand to the upper accumulator; then shift {acc, multiplier} right by 1.
- CALC, divide: restoring step on {rem, quot} each cycle; shift left, trial-subtract the divisor, keep the result if non-negative and set the quotient bit.
- Counter decrements each cycle; after WIDTH cycles go to FIX.
- FIX: apply the two's-complement negations recorded in PREP, write result_hi/result_lo, then go to DONE.
- DONE: done=1 for exactly one cycle. Next state is PREP if start is high in this cycle (back-to-back), else IDLE.
- Latency: start sampled at edge N gives done high in cycle N+WIDTH+3 (35 cycles for WIDTH=32).
- result_hi/result_lo hold their values until the next FIX; they are never cleared by start.
- start while busy is ignored: no latch, no error.
- Divide by zero: the full iteration still runs. Forced results are result_lo = all ones, result_hi = original opr_a, and div_by_zero=1 with done.
- Signed overflow (DIV MIN/−1): result_lo = MIN, result_hi = 0; this falls out of the abs/negate path with no special case.
- All arithmetic is unsigned internally at WIDTH+1 bits for the trial subtract; carries beyond 2·WIDTH are discarded.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined: multiplies compute the full signed/unsigned 2·WIDTH product in PREP using a single-cycle multiplier and skip CALC/FIX. done arrives in cycle N+2. Divide timing is unchanged.
- Undefined: multiplies use the iterative path with latency WIDTH+3. Results are bit-identical either way.

Decomposition:
- Package mdu_pkg holds:
  - op encodings (MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV);
  - the state enum (IDLE/PREP/CALC/FIX/DONE);
  - a function computing two's-complement negate.
- One sub-module, mdu_div_step: a purely combinational single restoring-division step of WIDTH+1 bits, instantiated once in CALC.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done at start+35, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1–34.
- MULT −7 × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=100, div_by_zero=1 with done. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- start re-asserted at cycles 5 and 20 of a divide → ignored, and the original result is unchanged. start held in the DONE cycle → second op begins immediately, with its done 35 cycles later.
- reset asserted at cycle 10 of a divide → next cycle: IDLE, busy=0, results=0, and no done pulse ever appears.
- With MDU_FAST_MULT_EN and MULTU 0x12345678 × 0x10 → done at start+2, hi=0x1, lo=0x23456780.
